// File: rtl/multicycle_decoder_if.sv
// Control bundle between the instruction register, the multicycle
// decoder and the datapath it steers.
interface multicycle_decoder_if #(
   parameter int ALU_CTRL_W = 3,
   parameter int REG_ADDR_W = 4
);
   logic [1:0]            Op;
   logic [5:0]            Funct;
   logic [REG_ADDR_W-1:0] Rd;
   logic                  CondEx;
   logic                  PCWrite;
   logic                  AdrSrc;
   logic                  MemW;
   logic                  IRWrite;
   logic                  RegW;
   logic [1:0]            ResultSrc;
   logic                  ALUSrcA;
   logic [1:0]            ALUSrcB;
   logic [1:0]            ImmSrc;
   logic [1:0]            RegSrc;
   logic [ALU_CTRL_W-1:0] ALUControl;
   logic [1:0]            FlagW;
   logic                  Illegal;
   logic [3:0]            State;

   modport master (
      input  Op, Funct, Rd, CondEx,
      output PCWrite, AdrSrc, MemW, IRWrite, RegW,
      output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
      output ALUControl, FlagW, Illegal, State
   );

   modport slave (
      output Op, Funct, Rd, CondEx,
      input  PCWrite, AdrSrc, MemW, IRWrite, RegW,
      input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
      input  ALUControl, FlagW, Illegal, State
   );
endinterface

// File: rtl/multicycle_decoder.sv
// Moore-sequenced multicycle ARM control decoder.
// Define CMP_EN to add CMP/TST (flag-only) data-processing ops.
module multicycle_decoder #(
   parameter int                    ALU_CTRL_W = 3,
   parameter int                    REG_ADDR_W = 4,
   parameter logic [REG_ADDR_W-1:0] PC_REG     = '1
) (
   input logic                clk,
   input logic                reset,
   multicycle_decoder_if.master bus
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECR   = 4'd6,
      EXECI   = 4'd7,
      ALUWB   = 4'd8,
      BRANCH  = 4'd9,
      ILLEGAL = 4'd10
   } state_t;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
   localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
   localparam logic [ALU_CTRL_W-1:0] ALU_ORR = ALU_CTRL_W'(3);
   localparam logic [ALU_CTRL_W-1:0] ALU_EOR = ALU_CTRL_W'(4);

   state_t state;
   state_t nxt;

   logic [ALU_CTRL_W-1:0] dp_op;
   logic                  dp_impl;
   logic                  dp_cmp;
   logic                  dp_s;
   logic                  dp_arith;
   logic [1:0]            dp_flags;
   logic                  dp_wr;
   logic                  pc_dst;
   logic                  ce;

   logic pcw;
   logic memw;
   logic irw;
   logic regw;
   logic [1:0] flagw;
   logic ill;

   assign ce     = bus.CondEx;
   assign pc_dst = (bus.Rd == PC_REG);

   always_comb begin
      nxt = FETCH;
      case (state)
         FETCH:  nxt = DECODE;
         DECODE: begin
            case (bus.Op)
               2'b01:   nxt = MEMADR;
               2'b00:   nxt = bus.Funct[5] ? EXECI : EXECR;
               2'b10:   nxt = BRANCH;
               default: nxt = ILLEGAL;
            endcase
         end
         MEMADR: nxt = bus.Funct[0] ? MEMRD : MEMWR;
         MEMRD:  nxt = MEMWB;
         EXECR:  nxt = ALUWB;
         EXECI:  nxt = ALUWB;
         default: nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= nxt;
   end

   // Unknown function codes fall back to ADD with the writeback dropped.
   always_comb begin
      dp_op   = ALU_ADD;
      dp_impl = 1'b1;
      dp_cmp  = 1'b0;
      case (bus.Funct[4:1])
         4'b0100: dp_op = ALU_ADD;
         4'b0010: dp_op = ALU_SUB;
         4'b0000: dp_op = ALU_AND;
         4'b1100: dp_op = ALU_ORR;
         4'b0001: dp_op = ALU_EOR;
`ifdef CMP_EN
         4'b1010: begin
            dp_op  = ALU_SUB;
            dp_cmp = 1'b1;
         end
         4'b1000: begin
            dp_op  = ALU_AND;
            dp_cmp = 1'b1;
         end
`endif
         default: dp_impl = 1'b0;
      endcase
   end

   assign dp_s     = bus.Funct[0] | dp_cmp;
   assign dp_arith = (dp_op == ALU_ADD) || (dp_op == ALU_SUB);
   assign dp_flags = dp_impl ? {dp_s & ce, dp_s & ce & dp_arith} : 2'b00;
   assign dp_wr    = dp_impl & ~dp_cmp;

   always_comb begin
      pcw            = 1'b0;
      memw           = 1'b0;
      irw            = 1'b0;
      regw           = 1'b0;
      flagw          = 2'b00;
      ill            = 1'b0;
      bus.AdrSrc     = 1'b0;
      bus.ResultSrc  = 2'b00;
      bus.ALUSrcA    = 1'b0;
      bus.ALUSrcB    = 2'b00;
      bus.ALUControl = ALU_ADD;
      case (state)
         FETCH: begin
            irw         = 1'b1;
            pcw         = 1'b1;
            bus.ALUSrcA   = 1'b1;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
         end
         DECODE: begin
            bus.ALUSrcA   = 1'b1;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
         end
         MEMADR: begin
            bus.ALUSrcB = 2'b01;
         end
         MEMRD: begin
            bus.AdrSrc = 1'b1;
         end
         MEMWB: begin
            bus.ResultSrc = 2'b01;
            regw = ce;
            pcw  = ce & pc_dst;
         end
         MEMWR: begin
            bus.AdrSrc = 1'b1;
            memw = ce;
         end
         EXECR: begin
            bus.ALUControl = dp_op;
            flagw = dp_flags;
         end
         EXECI: begin
            bus.ALUSrcB    = 2'b01;
            bus.ALUControl = dp_op;
            flagw = dp_flags;
         end
         ALUWB: begin
            regw = ce & dp_wr;
            pcw  = ce & dp_wr & pc_dst;
         end
         BRANCH: begin
            bus.ALUSrcB   = 2'b01;
            bus.ResultSrc = 2'b10;
            pcw = ce;
         end
         ILLEGAL: ill = 1'b1;
         default: ;
      endcase
   end

   // Reset is asynchronous, so enables are masked directly by it.
   assign bus.PCWrite = pcw  & ~reset;
   assign bus.MemW    = memw & ~reset;
   assign bus.IRWrite = irw  & ~reset;
   assign bus.RegW    = regw & ~reset;
   assign bus.FlagW   = flagw & {2{~reset}};
   assign bus.Illegal = ill  & ~reset;

   assign bus.ImmSrc = bus.Op;
   assign bus.RegSrc = {bus.Op == 2'b01, bus.Op == 2'b10};
   assign bus.State  = state;

endmodule

// File: tb/tb_multicycle_decoder.sv
// Directed and randomized checks of multicycle_decoder against a
// per-instruction-class cycle model.
module tb_multicycle_decoder;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   multicycle_decoder_if #(.ALU_CTRL_W(3), .REG_ADDR_W(4)) bus ();

   multicycle_decoder #(
      .ALU_CTRL_W(3),
      .REG_ADDR_W(4),
      .PC_REG(4'hF)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] observed();
      return {bus.State, bus.PCWrite, bus.AdrSrc, bus.MemW,
              bus.IRWrite, bus.RegW, bus.ResultSrc, bus.ALUSrcA,
              bus.ALUSrcB, bus.ImmSrc, bus.RegSrc, bus.ALUControl,
              bus.FlagW, bus.Illegal};
   endfunction

   // 0=LDR 1=STR 2=data-processing 3=branch 4=illegal
   function automatic int iclass(logic [1:0] op, logic [5:0] f);
      if (op == 2'b01) return f[0] ? 0 : 1;
      if (op == 2'b00) return 2;
      if (op == 2'b10) return 3;
      return 4;
   endfunction

   function automatic int ncycles(logic [1:0] op, logic [5:0] f);
      int lat [5] = '{5, 4, 4, 3, 3};
      return lat[iclass(op, f)];
   endfunction

   function automatic logic [23:0] model(int k, logic [1:0] op,
                                         logic [5:0] f, logic [3:0] rd,
                                         logic ce, logic rst);
      logic [3:0] st = 4'd0;
      logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, sa = 0, ill = 0;
      logic [1:0] res = 0, sb = 0, fw = 0;
      logic [2:0] alu = 3'd0;
      logic impl = 1, flagonly = 0, wr;
      int c = iclass(op, f);
      case (f[4:1])
         4'd4:  alu = 3'd0;
         4'd2:  alu = 3'd1;
         4'd0:  alu = 3'd2;
         4'd12: alu = 3'd3;
         4'd1:  alu = 3'd4;
`ifdef CMP_EN
         4'd10: begin alu = 3'd1; flagonly = 1; end
         4'd8:  begin alu = 3'd2; flagonly = 1; end
`endif
         default: impl = 0;
      endcase
      wr = impl && !flagonly;
      if (k == 0) begin
         st = 0; irw = 1; pcw = 1; sa = 1; sb = 2; res = 2;
      end else if (k == 1) begin
         st = 1; sa = 1; sb = 2; res = 2;
      end else if (k == 2) begin
         if (c <= 1) begin
            st = 2; sb = 1;
         end else if (c == 2) begin
            st = f[5] ? 4'd7 : 4'd6;
            sb = f[5] ? 2'd1 : 2'd0;
            if (impl) begin
               fw[1] = (f[0] || flagonly) && ce;
               fw[0] = fw[1] && (alu <= 3'd1);
            end
         end else if (c == 3) begin
            st = 9; sb = 1; res = 2; pcw = ce;
         end else begin
            st = 10; ill = 1;
         end
         if (c == 2) alu = alu; else alu = 3'd0;
      end else if (k == 3) begin
         if (c == 0) begin
            st = 3; adr = 1;
         end else if (c == 1) begin
            st = 5; adr = 1; mw = ce;
         end else begin
            st = 8; rw = ce && wr; pcw = ce && wr && rd == 4'hF;
         end
      end else begin
         st = 4; res = 1; rw = ce; pcw = ce && rd == 4'hF;
      end
      if (k != 2 || c != 2) alu = 3'd0;
      if (rst) begin
         pcw = 0; mw = 0; irw = 0; rw = 0; fw = 0; ill = 0;
      end
      return {st, pcw, adr, mw, irw, rw, res, sa, sb, op,
              op == 2'b01, op == 2'b10, alu, fw, ill};
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Caller is #1 past an edge with the DUT in FETCH; abort<0 runs to end.
   task automatic run_instr(logic [1:0] op, logic [5:0] f, logic [3:0] rd,
                            logic ce, int abort);
      bus.Op = op; bus.Funct = f; bus.Rd = rd; bus.CondEx = ce;
      #0;
      for (int k = 0; k < ncycles(op, f); k++) begin
         chk($sformatf("op%0d f%02h rd%0d ce%0d cyc%0d", op, f, rd, ce, k),
             32'(observed()), 32'(model(k, op, f, rd, ce, 1'b0)));
         if (k == abort) begin
            #2 reset = 1'b1;
            #1;
            chk("rst_async_state", 32'(bus.State), 32'd0);
            chk("rst_async_irw", 32'(bus.IRWrite), 32'd0);
            chk("rst_async_regw", 32'(bus.RegW), 32'd0);
            @(posedge clk); #1;
            chk("rst_hold", 32'(observed()),
                32'(model(0, op, f, rd, ce, 1'b1)));
            #2 reset = 1'b0;
            #1;
            return;
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] rd;
      logic       ce;
      logic [3:0] codes [7] = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd1, 4'd10, 4'd8};
      bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.CondEx = 1'b0;
      @(posedge clk); #1;
      chk("reset_state", 32'(observed()),
          32'(model(0, 2'b00, 6'd0, 4'd0, 1'b0, 1'b1)));
      @(posedge clk); #1;
      chk("reset_hold", 32'(observed()),
          32'(model(0, 2'b00, 6'd0, 4'd0, 1'b0, 1'b1)));
      reset = 1'b0;
      run_instr(2'b00, 6'b001001, 4'd3, 1'b1, 2);
      run_instr(2'b01, 6'b011001, 4'd2, 1'b1, -1);
      run_instr(2'b01, 6'b011000, 4'd2, 1'b0, -1);
      run_instr(2'b00, 6'b001001, 4'd1, 1'b1, -1);
      run_instr(2'b00, 6'b011001, 4'd1, 1'b1, -1);
      run_instr(2'b00, 6'b000000, 4'd15, 1'b1, -1);
      run_instr(2'b01, 6'b011001, 4'd15, 1'b1, -1);
      run_instr(2'b10, 6'b000000, 4'd0, 1'b0, -1);
      run_instr(2'b10, 6'b000000, 4'd0, 1'b1, -1);
      run_instr(2'b11, 6'b000000, 4'd0, 1'b1, -1);
      run_instr(2'b00, 6'b010101, 4'd4, 1'b1, -1);
      run_instr(2'b00, 6'b110001, 4'd15, 1'b1, -1);
      run_instr(2'b00, 6'b101111, 4'd5, 1'b1, -1);
      for (int i = 0; i < 300; i++) begin
         op = 2'($urandom_range(0, 3));
         f  = 6'($urandom);
         if ($urandom_range(0, 1) == 1) f[4:1] = codes[$urandom_range(0, 6)];
         rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
         ce = ($urandom_range(0, 3) != 0);
         run_instr(op, f, rd, ce, ($urandom_range(0, 19) == 0) ? 1 : -1);
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/multicycle_decoder.md
Name: multicycle_decoder

Overview:
- Multicycle successor to the single-cycle ARM decoder.
- A Moore FSM sequences each instruction over 3-5 cycles; shared memory and ALU are steered by per-state controls.
- Sits between the instruction register and the datapath. External conditional logic supplies CondEx; this block gates architectural writes with it.
- Generalised ALU control width, with EOR and an illegal-opcode state added.

Parameters:
- ALU_CTRL_W, 3: ALUControl width; must be ≥3 (5 ops encoded).
- REG_ADDR_W, 4: register-index width of Rd.
- PC_REG, all-ones of REG_ADDR_W: register index treated as PC.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- Op  in  2  instruction bits [27:26].
- Funct  in  6  instruction bits [25:20].
- Rd  in  REG_ADDR_W  destination register field.
- CondEx  in  1  condition-passed flag from external condition logic; valid from DECODE onward.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- MemW  out  1  data memory write enable.
- IRWrite  out  1  instruction register enable.
- RegW  out  1  register file write enable.
- ResultSrc  out  2  result select: 00=ALUOut, 01=ReadData, 10=ALUResult.
- ALUSrcA  out  1  ALU A select: 0=RD1, 1=PC.
- ALUSrcB  out  2  ALU B select: 00=RD2, 01=ExtImm, 10=constant 4.
- ImmSrc  out  2  immediate-extend select; equals Op.
- RegSrc  out  2  [0]=1 iff Op==10; [1]=1 iff Op==01.
- ALUControl  out  ALU_CTRL_W  ADD=0, SUB=1, AND=2, ORR=3, EOR=4.
- FlagW  out  2  [1] writes NZ, [0] writes CV.
- Illegal  out  1  high for the one cycle in ILLEGAL.
- State  out  4  current-state encoding, for debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, ILLEGAL=10. Any other encoding returns to FETCH.
- Reset:
  - reset high forces State=FETCH immediately (async).
  - While reset is high, all enables (PCWrite, MemW, IRWrite, RegW, FlagW, Illegal) are 0; the select outputs take their FETCH values.
  - Reset mid-instruction abandons the instruction; no write occurs.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1 (unconditional). Next state DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state by opcode:
  - Op=01 -> MEMADR.
  - Op=00 with Funct[5]=0 -> EXECR.
  - Op=00 with Funct[5]=1 -> EXECI.
  - Op=10 -> BRANCH.
  - Op=11 -> ILLEGAL.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Next state: Funct[0] ? MEMRD : MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Next state MEMWB.
- MEMWB: ResultSrc=01, RegW=CondEx. Next state FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemW=CondEx. Next state FETCH.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALU decode active. Next state ALUWB.
- EXECI: ALUSrcA=0, ALUSrcB=01, ALU decode active. Next state ALUWB.
- ALUWB: ResultSrc=00, RegW=CondEx. Next state FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ADD, PCWrite=CondEx. Next state FETCH.
- ILLEGAL: all enables 0, Illegal=1. Next state FETCH.
- ALU decode (EXECR/EXECI only), on Funct[4:1]:
  - 0100 -> ADD, 0010 -> SUB, 0000 -> AND, 1100 -> ORR, 0001 -> EOR.
  - Any other code -> ADD, and the ALUWB write is suppressed (treated as NOP).
  - FlagW[1] = Funct[0] & CondEx.
  - FlagW[0] = Funct[0] & CondEx & (ADD|SUB).
  - In all other states ALUControl=ADD and FlagW=00.
- PC-destination writes: in MEMWB or ALUWB with Rd==PC_REG, PCWrite=CondEx and ResultSrc is unchanged, so the result loads into PC.
- CondEx=0: the instruction still takes its full cycle count; only RegW, MemW, PCWrite (except in FETCH) and FlagW are suppressed.
- Latency:
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Data-processing: 4 cycles.
  - Branch: 3 cycles.
  - Illegal: 3 cycles.
- All outputs are combinational decodes of State plus the registered-instruction fields; there are no glitch-sensitive paths.

Optional Feature:
- Macro CMP_EN.
- With CMP_EN defined:
  - Funct[4:1]=1010 (CMP) decodes to SUB.
  - Funct[4:1]=1000 (TST) decodes to AND.
  - Both force FlagW as for S=1, gated by CondEx.
  - Both suppress RegW in ALUWB.
- Without CMP_EN: both codes take the unimplemented path (ADD, no write, FlagW=00).

Test Plan:
- Reset asserted mid-EXECR with State=6 -> State=0 the same cycle; IRWrite=0 and RegW=0 until release; the first cycle after release has IRWrite=1 and PCWrite=1.
- LDR (Op=01, Funct=011001, CondEx=1) -> States 0,1,2,3,4; MemW never 1; RegW=1 only in MEMWB with ResultSrc=01.
- STR with CondEx=0 -> States 0,1,2,5; MemW=0 throughout; returns to FETCH.
- ADDS register (Op=00, Funct=001001, CondEx=1) -> EXECR: ALUControl=0, FlagW=11; ALUWB: RegW=1. Repeat with Funct=011001 (ORRS) -> FlagW=10, ALUControl=3.
- Op=00, Funct=000000, Rd=15, CondEx=1 -> in ALUWB, RegW=1 and PCWrite=1. Op=10 with CondEx=0 -> BRANCH has PCWrite=0.
- Op=11 -> State 10 with Illegal=1 for one cycle, then FETCH. With CMP_EN, Funct=010101 -> ALUControl=1, FlagW=11, RegW=0 in ALUWB.
